// File: rtl/ssp_wb_pkg.sv
// ---------------------------------------------------------------------------
// ssp_wb_pkg
// Shared definitions for the SSP Wishbone slave:
//   - register offsets decoded from adr_i[3:2]
//   - STATUS and CTRL bit positions
//   - bus-handshake FSM state encoding
//   - CTRL read-back helper
// ---------------------------------------------------------------------------
package ssp_wb_pkg;

    // Register offsets (adr_i[3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 12;
    localparam int ST_CNT_W      = 3;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

    // Bus handshake FSM
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // CTRL reads back only the enable bit; flush is a strobe and reads 0.
    function automatic logic [31:0] ctrl_readback(input logic en);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN] = en;
        return v;
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// ---------------------------------------------------------------------------
// ssp_fifo
// Synchronous FIFO used for both the TX and RX byte streams.
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-low reset (pointers/count only)
//   i_push   in   write i_data this edge (ignored when full unless popping)
//   i_data   in   WIDTH-bit write data
//   i_pop    in   discard head entry this edge (ignored when empty)
//   i_flush  in   empty the FIFO; overrides push and pop
//   o_data   out  head entry (valid when !o_empty)
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
//   o_count  out  number of entries held
// ---------------------------------------------------------------------------
module ssp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ssp_wb_slave.sv
// ---------------------------------------------------------------------------
// ssp_wb_slave
// Wishbone slave exposing the SSP TX/RX byte streams as four registers:
//   0 DATA   (W: push TX byte, R: pop RX byte)
//   1 STATUS (RO, reading clears the sticky error flags)
//   2 CTRL   ([0] en, [1] flush strobe)
//   3 reserved
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   adr_i[25:0]             [25:4] must equal BASE_ADDR, [3:2] register
//   dat_i / dat_o           write / read data
//   we_i, stb_i, cyc_i      Wishbone cycle controls
//   tagn_i / tagn_o         tag, echoed while ack_o is high
//   ack_o                   one-cycle acknowledge
//   tx_data, tx_valid       TX FIFO head to SSP, tx_ready pops it
//   rx_data, rx_valid       byte from SSP, no backpressure
// ---------------------------------------------------------------------------
module ssp_wb_slave
    import ssp_wb_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR = 22'h0,
    parameter int          DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [25:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        tagn_i,
    output logic        ack_o,
    output logic        tagn_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_dat;
    logic        r_tag;
    logic        r_en;
    logic        r_rx_overrun;
    logic        r_tx_drop;

    logic        w_sel;
    logic        w_start;
    logic [1:0]  w_reg;
    logic        w_data_wr;
    logic        w_data_rd;
    logic        w_stat_rd;
    logic        w_ctrl_wr;
    logic        w_flush;

    logic [7:0]    w_tx_head;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;
    logic          w_tx_push;
    logic          w_tx_pop;

    logic [7:0]    w_rx_head;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_rx_count;
    logic          w_rx_push;
    logic          w_rx_pop;

    logic        w_tx_drop_evt;
    logic        w_rx_ovr_evt;
    logic [31:0] w_tx_cnt_ext;
    logic [31:0] w_rx_cnt_ext;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    // ---------------- decode ----------------
    assign w_sel     = cyc_i & stb_i & (adr_i[25:4] == BASE_ADDR);
    // Only IDLE accepts a strobe, so a strobe held past its ack is not replayed.
    assign w_start   = (r_state == S_IDLE) & w_sel;
    assign w_reg     = adr_i[3:2];
    assign w_data_wr = w_start &  we_i & (w_reg == REG_DATA);
    assign w_data_rd = w_start & ~we_i & (w_reg == REG_DATA);
    assign w_stat_rd = w_start & ~we_i & (w_reg == REG_STATUS);
    assign w_ctrl_wr = w_start &  we_i & (w_reg == REG_CTRL);
    assign w_flush   = w_ctrl_wr & dat_i[CTRL_FLUSH];

    // ---------------- FIFOs ----------------
    assign tx_valid  = ~w_tx_empty & r_en;
    assign tx_data   = w_tx_head;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_tx_push = w_data_wr & (~w_tx_full | w_tx_pop);

    assign w_rx_pop  = w_data_rd & ~w_rx_empty;
    // A byte arriving with a flush is discarded along with the FIFO contents.
    assign w_rx_push = rx_valid & ~w_flush & (~w_rx_full | w_rx_pop);

    ssp_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_tx_push),
        .i_data  (dat_i[7:0]),
        .i_pop   (w_tx_pop),
        .i_flush (w_flush),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    ssp_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (w_rx_pop),
        .i_flush (w_flush),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // ---------------- sticky flags ----------------
    assign w_tx_drop_evt = w_data_wr & w_tx_full & ~w_tx_pop;
    assign w_rx_ovr_evt  = rx_valid & w_rx_full & ~w_rx_pop & ~w_flush;

    // Priority: flush clears, a new event sets, a STATUS read clears.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tx_drop    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else if (w_flush) begin
            r_tx_drop    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_tx_drop_evt) begin
                r_tx_drop <= 1'b1;
            end else if (w_stat_rd) begin
                r_tx_drop <= 1'b0;
            end
            if (w_rx_ovr_evt) begin
                r_rx_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_rx_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_en <= dat_i[CTRL_EN];
        end
    end

    // ---------------- read path ----------------
    // Counts are zero-extended, then cut to the 3-bit STATUS fields.
    assign w_tx_cnt_ext = 32'(w_tx_count);
    assign w_rx_cnt_ext = 32'(w_rx_count);

    always_comb begin
        w_status = '0;
        w_status[ST_TX_FULL]    = w_tx_full;
        w_status[ST_TX_EMPTY]   = w_tx_empty;
        w_status[ST_RX_FULL]    = w_rx_full;
        w_status[ST_RX_EMPTY]   = w_rx_empty;
        w_status[ST_RX_OVERRUN] = r_rx_overrun;
        w_status[ST_TX_DROP]    = r_tx_drop;
        w_status[ST_TX_CNT_LSB +: ST_CNT_W] = w_tx_cnt_ext[ST_CNT_W-1:0];
        w_status[ST_RX_CNT_LSB +: ST_CNT_W] = w_rx_cnt_ext[ST_CNT_W-1:0];
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA:   w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            REG_STATUS: w_rdata = w_status;
            REG_CTRL:   w_rdata = ctrl_readback(r_en);
            default:    w_rdata = '0;
        endcase
    end

    // dat_o holds the last read value until the next read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_dat <= '0;
            r_tag <= 1'b0;
        end else if (w_start) begin
            r_tag <= tagn_i;
            if (!we_i) begin
                r_dat <= w_rdata;
            end
        end
    end

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_ACK;
            S_ACK:   w_next = cyc_i ? S_HOLD : S_IDLE;
            S_HOLD:  if (!cyc_i || !stb_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o  = (r_state == S_ACK);
        tagn_o = (r_state == S_ACK) & r_tag;
        dat_o  = r_dat;
    end

    assign w_unused = ^{adr_i[1:0], dat_i[31:8], w_tx_cnt_ext[31:ST_CNT_W],
                        w_rx_cnt_ext[31:ST_CNT_W]};

endmodule
